vga_frame_reader: RTL and testbench
===================================

# vga_frame_reader

Display-side consumer of the capture frame buffer: generates 640x480@60 VGA timing in the pixel-clock domain, reads the 160x100 8-bit intensity buffer that the capture stage fills (linear address 0..15999, row-major), upscales it 4x in both axes into a vertically centred 640x400 window, and drives 4-bit RGB plus syncs. It sits between the buffer's read port and the board's VGA resistor DAC.

## Interface
- H_VIS, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixel clocks; total is 800.
- V_VIS, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines; total is 525.
- SRC_W, 160; SRC_H, 100: source image size in buffer pixels.
- SCALE_LOG2, 2: upscale factor is 4.
- V_OFS, 40: first visible line of the image window, equal to (V_VIS - SRC_H*4)/2.
- V_CLK  in  1  pixel clock, 25.175 MHz; all logic is on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  display enable; sampled only at frame start.
- RD_ADDR  out  14  buffer read address.
- RD_EN  out  1  buffer read enable.
- RD_DATA  in  8  buffer read data, valid 1 cycle after RD_ADDR/RD_EN (registered read).
- VGA_HS, VGA_VS  out  1 each  syncs, active low.
- VGA_DE  out  1  high while in the 640x480 visible area.
- VGA_R, VGA_G, VGA_B  out  4 each  pixel colour.
- FRAME_START  out  1  one-cycle pulse aligned with the output pixel (0,0).

## Operation
- The free-running counters H (0..799) and V (0..524) form stage 0. H wraps 799->0. V increments when H wraps, and V wraps 524->0 at H=799,V=524.
- Visible area: H<640 and V<480. Image window: visible, and V_OFS<=V<V_OFS+400.
- Address generation:
  - RD_ADDR = ((V-V_OFS)>>2)*SRC_W + (H>>2).
  - Computed incrementally: a line-base register is cleared at frame start and advanced by SRC_W after each 4th window line. A column counter advances every 4th pixel.
  - No multiplier is used.
  - 14-bit result; maximum 15999.
- RD_EN is high only inside the image window. Outside it, RD_ADDR holds its last value.
- Pixel: if the delayed window flag and the frame-latched enable are both set, then R=G=B=RD_DATA[7:4]. Otherwise R=G=B=0. The output is greyscale.
- ENABLE is latched into the frame-enable register at H=0,V=0 only, so a frame is never torn.
- HS is low for H in [656,752). VS is low for V in [490,492).

## Timing
- Pipeline:
  - Stage 0: counters at cycle n.
  - Stage 1: RD_ADDR/RD_EN registered at n+1.
  - Stage 2: RD_DATA at n+2.
  - Stage 3: RGB registered at n+3.
- VGA_HS, VGA_VS, VGA_DE, the window flag and FRAME_START are delayed through a 3-stage shift so that all outputs align with RGB. Total latency is 3 cycles from counter to pins.
- Reset values (the cycle after RESET is sampled high):
  - H=0, V=0.
  - RD_ADDR=0, RD_EN=0.
  - VGA_HS=1, VGA_VS=1, VGA_DE=0.
  - RGB=0, FRAME_START=0.
  - The frame-enable register and the delay pipes are cleared.
- Recovery from reset:
  - The first cycle with RESET low evaluates stage 0 at H=0,V=0.
  - FRAME_START pulses 3 cycles later.
  - Syncs are inactive until their first natural assertion.
- Reset mid-frame aborts the line immediately. There are no partial sync pulses after reset; the pipes are cleared.
- Simultaneous H and V wrap at (799,524): next state is (0,0). The enable latch and the line-base clear take effect in the same cycle.
- Line-base boundary: after window line 399 (V=439), the base is not advanced further, so the address never exceeds 15999.
- Horizontal boundary: the column counter reloads to 0 at H=0 on every line.

## Test plan
- Reset, then run one full frame with ENABLE=1:
  - Exactly 525 HS pulses of 96 clocks each.
  - 1 VS pulse of 1600 clocks.
  - DE high for 640x480 clocks.
  - Frame period 420000 clocks.
  - FRAME_START once.
- Address sweep, with the model buffer returning data = address[7:0]:
  - Stage 0 at (0,40) -> RD_ADDR 0.
  - (4,40) -> 1.
  - (0,44) -> 160.
  - (639,439) -> 15999.
  - RD_EN=0 at (0,39), (0,440) and (640,40).
- Pixel alignment: buffer address 0 returns 0xF0 and all others 0x00 -> RGB=0xF on exactly the output pixels x 0..3, y 40..43 (3 cycles after stage 0). Black elsewhere, including the border lines 0..39.
- ENABLE toggled low at mid-frame (V=200) -> the current frame completes with image. The next frame is all-black with syncs unchanged. Raising ENABLE restores the image only from the following frame start.
- RESET asserted for 1 cycle at (300,250) -> all outputs take reset values the next cycle. The pipeline restarts at (0,0). FRAME_START appears 3 cycles after reset release.
- Long run of 3 frames -> no drift: FRAME_START spacing is exactly 420000 cycles, and RD_ADDR never exceeds 15999.

Source files
------------

// File: rtl/vga_frame_reader_if.sv
// rtl/vga_frame_reader_if.sv - frame buffer read port between the reader and the buffer
// The buffer answers with a registered read: rd_data follows rd_addr/rd_en by one clock.
interface vga_frame_reader_if;
  logic [13:0] rd_addr;
  logic        rd_en;
  logic [7:0]  rd_data;

  modport master (output rd_addr, output rd_en, input rd_data);
  modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - VGA timing plus 4x upscaled greyscale readout of the capture buffer
// Stage 0 counters, stage 1 read request, stage 2 buffer data, stage 3 registered pins.
module vga_frame_reader #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SRC_W      = 160,
  parameter int SRC_H      = 100,
  parameter int SCALE_LOG2 = 2,
  parameter int V_OFS      = 40
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  vga_frame_reader_if.master         io_buf,
  output logic                       o_vga_hs,
  output logic                       o_vga_vs,
  output logic                       o_vga_de,
  output logic [3:0]                 o_vga_r,
  output logic [3:0]                 o_vga_g,
  output logic [3:0]                 o_vga_b,
  output logic                       o_frame_start
);

  localparam int WIN_LINES = SRC_H << SCALE_LOG2;

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] WIN_BEG  = 10'(V_OFS);
  localparam logic [9:0] WIN_END  = 10'(V_OFS + WIN_LINES);
  localparam logic [9:0] WIN_LAST = 10'(V_OFS + WIN_LINES - 1);
  localparam logic [13:0] SRC_W_C = 14'(SRC_W);
  localparam logic [SCALE_LOG2-1:0] SUB_ONE = SCALE_LOG2'(1);

  logic [9:0]            r_h;
  logic [9:0]            r_v;
  logic [SCALE_LOG2-1:0] r_hsub;
  logic [SCALE_LOG2-1:0] r_vsub;
  logic [13:0]           r_col;
  logic [13:0]           r_line_base;
  logic [13:0]           r_rd_addr;
  logic                  r_rd_en;
  logic                  r_frame_en;
  logic [2:0]            r_hs_d;
  logic [2:0]            r_vs_d;
  logic [2:0]            r_de_d;
  logic [2:0]            r_fs_d;
  logic [1:0]            r_win_d;
  logic [3:0]            r_pix;

  logic w_h_wrap;
  logic w_frame_wrap;
  logic w_vis;
  logic w_vwin;
  logic w_win;
  logic w_hs;
  logic w_vs;
  logic w_fs;

  assign w_h_wrap     = (r_h == H_LAST);
  assign w_frame_wrap = w_h_wrap && (r_v == V_LAST);
  assign w_vis        = (r_h < H_VIS_C) && (r_v < V_VIS_C);
  assign w_vwin       = (r_v >= WIN_BEG) && (r_v < WIN_END);
  assign w_win        = (r_h < H_VIS_C) && w_vwin;
  assign w_hs         = !((r_h >= HS_BEG) && (r_h < HS_END));
  assign w_vs         = !((r_v >= VS_BEG) && (r_v < VS_END));
  assign w_fs         = (r_h == 10'd0) && (r_v == 10'd0);

  // r_col tracks H>>SCALE_LOG2 without a shift of the counter itself.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h    <= '0;
      r_v    <= '0;
      r_hsub <= '0;
      r_col  <= '0;
    end else if (w_h_wrap) begin
      r_h    <= '0;
      r_hsub <= '0;
      r_col  <= '0;
      r_v    <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
    end else begin
      r_h    <= r_h + 10'd1;
      r_hsub <= r_hsub + SUB_ONE;
      if (r_hsub == '1) r_col <= r_col + 14'd1;
    end
  end

  // The last window line does not advance the base, keeping the address in range.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_frame_wrap) begin
      r_line_base <= '0;
      r_vsub      <= '0;
    end else if (w_h_wrap && w_vwin) begin
      r_vsub <= r_vsub + SUB_ONE;
      if ((r_vsub == '1) && (r_v != WIN_LAST)) r_line_base <= r_line_base + SRC_W_C;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_addr <= '0;
      r_rd_en   <= 1'b0;
    end else begin
      r_rd_en <= w_win;
      if (w_win) r_rd_addr <= r_line_base + r_col;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_en <= 1'b0;
    end else if (w_fs) begin
      r_frame_en <= i_enable;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hs_d  <= '1;
      r_vs_d  <= '1;
      r_de_d  <= '0;
      r_fs_d  <= '0;
      r_win_d <= '0;
      r_pix   <= '0;
    end else begin
      r_hs_d  <= {r_hs_d[1:0], w_hs};
      r_vs_d  <= {r_vs_d[1:0], w_vs};
      r_de_d  <= {r_de_d[1:0], w_vis};
      r_fs_d  <= {r_fs_d[1:0], w_fs};
      r_win_d <= {r_win_d[0], w_win};
      r_pix   <= (r_win_d[1] && r_frame_en) ? io_buf.rd_data[7:4] : 4'h0;
    end
  end

  assign io_buf.rd_addr = r_rd_addr;
  assign io_buf.rd_en   = r_rd_en;
  assign o_vga_hs       = r_hs_d[2];
  assign o_vga_vs       = r_vs_d[2];
  assign o_vga_de       = r_de_d[2];
  assign o_frame_start  = r_fs_d[2];
  assign o_vga_r        = r_pix;
  assign o_vga_g        = r_pix;
  assign o_vga_b        = r_pix;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - scoreboard bench for vga_frame_reader on a shrunken raster
module tb_vga_frame_reader;
  localparam int H_VIS = 32, H_FP = 2, H_SYNC = 4, H_BP = 2;
  localparam int V_VIS = 24, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int SRC_W = 8, SRC_H = 4, V_OFS = 4;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  typedef struct packed {
    logic        en;
    logic [13:0] addr;
  } a_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic hs, vs, de, fs;
  logic [3:0] r, g, b;

  vga_frame_reader_if bus();

  vga_frame_reader #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE_LOG2(2), .V_OFS(V_OFS)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .io_buf(bus.master),
    .o_vga_hs(hs), .o_vga_vs(vs), .o_vga_de(de),
    .o_vga_r(r), .o_vga_g(g), .o_vga_b(b), .o_frame_start(fs)
  );

  always #5 clk = ~clk;

  int mem_mode = 0;

  function automatic logic [7:0] mem_data(input logic [13:0] a);
    if (mem_mode == 0) return a[7:0];
    return (a == 14'd0) ? 8'hF0 : 8'h00;
  endfunction

  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem_data(bus.rd_addr);

  int checks = 0;
  int errors = 0;
  a_exp_t q_a[$];
  logic [15:0] q_p[$];
  int mh = 0, mv = 0, cyc = 0, last_fs = -1;
  logic en_model = 1'b0;
  logic [13:0] last_addr = '0;
  int n_hs, n_vs, n_de, n_fs, n_img, n_rd, max_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cur();
    logic vis, win, hs_e, vs_e, fs_e;
    int addr;
    logic [7:0] d;
    logic [3:0] px;
    a_exp_t ea;
    vis  = (mh < H_VIS) && (mv < V_VIS);
    win  = vis && (mv >= V_OFS) && (mv < V_OFS + SRC_H * 4);
    addr = win ? ((mv - V_OFS) / 4) * SRC_W + mh / 4 : 0;
    if (mh == 0 && mv == 0) en_model = enable;
    d    = mem_data(14'(addr));
    px   = (win && en_model) ? d[7:4] : 4'h0;
    hs_e = !((mh >= H_VIS + H_FP) && (mh < H_VIS + H_FP + H_SYNC));
    vs_e = !((mv >= V_VIS + V_FP) && (mv < V_VIS + V_FP + V_SYNC));
    fs_e = (mh == 0) && (mv == 0);
    ea.en   = win;
    ea.addr = 14'(addr);
    q_a.push_back(ea);
    q_p.push_back({hs_e, vs_e, vis, fs_e, px, px, px});
    mh++;
    if (mh == H_TOT) begin
      mh = 0;
      mv++;
      if (mv == V_TOT) mv = 0;
    end
  endtask

  task automatic tick();
    a_exp_t ea;
    logic [15:0] ep;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (q_a.size() >= 1) begin
      ea = q_a.pop_front();
      chk("rd_en", 32'(bus.rd_en), 32'(ea.en));
      if (ea.en) begin
        chk("rd_addr", 32'(bus.rd_addr), 32'(ea.addr));
        last_addr = ea.addr;
      end else begin
        chk("rd_addr_hold", 32'(bus.rd_addr), 32'(last_addr));
      end
    end
    if (q_p.size() >= 3) begin
      ep = q_p.pop_front();
      chk("pins", 32'({hs, vs, de, fs, r, g, b}), 32'(ep));
    end
    if (!hs) n_hs++;
    if (!vs) n_vs++;
    if (de) n_de++;
    if (r != 4'h0) n_img++;
    if (bus.rd_en) n_rd++;
    if (int'(bus.rd_addr) > max_addr) max_addr = int'(bus.rd_addr);
    if (fs) begin
      n_fs++;
      if (last_fs >= 0) chk("fs_spacing", 32'(cyc - last_fs), 32'(FRAME));
      last_fs = cyc;
    end
    push_cur();
  endtask

  task automatic clear_stats();
    n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0; n_img = 0; n_rd = 0; max_addr = 0;
  endtask

  task automatic run_to(input int h, input int v);
    while (!(mh == h && mv == v)) tick();
  endtask

  // Leaves the model at (3,0) so the next FRAME ticks compare exactly one output frame.
  task automatic measure(input int img);
    run_to(3, 0);
    clear_stats();
    repeat (FRAME) tick();
    chk("hs_low_clocks", 32'(n_hs), 32'(V_TOT * H_SYNC));
    chk("vs_low_clocks", 32'(n_vs), 32'(V_SYNC * H_TOT));
    chk("de_clocks", 32'(n_de), 32'(H_VIS * V_VIS));
    chk("fs_count", 32'(n_fs), 32'd1);
    chk("rd_en_clocks", 32'(n_rd), 32'(H_VIS * SRC_H * 4));
    chk("lit_pixels", 32'(n_img), 32'(img));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("rst_hs", 32'(hs), 32'd1);
    chk("rst_vs", 32'(vs), 32'd1);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_rgb", 32'({r, g, b}), 32'd0);
    chk("rst_fs", 32'(fs), 32'd0);
    rst = 1'b0;
    q_a.delete();
    q_p.delete();
    mh = 0;
    mv = 0;
    last_addr = '0;
    last_fs = -1;
    push_cur();
  endtask

  initial begin
    int k;
    clear_stats();
    do_reset();
    tick();
    tick();
    measure(256);
    chk("max_addr", 32'(max_addr), 32'(SRC_W * SRC_H - 1));

    mem_mode = 1;
    measure(16);

    mem_mode = 0;
    run_to(0, 12);
    enable = 1'b0;
    measure(0);
    run_to(0, 12);
    enable = 1'b1;
    measure(256);

    run_to(20, 12);
    do_reset();
    k = 0;
    do begin
      tick();
      k++;
    end while (!fs && k < 10);
    chk("fs_after_reset", 32'(k), 32'd3);

    clear_stats();
    repeat (3 * FRAME) tick();
    chk("fs_count_3frames", 32'(n_fs), 32'd3);
    chk("max_addr_3frames", 32'(max_addr), 32'(SRC_W * SRC_H - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
